subleq_mem_arbiter: RTL and testbench
=====================================

# subleq_mem_arbiter

Shares the single-port word RAM of the SUBLEQ machine between the `subleq` core and a debug/loader port driven from board switches/GPIO. It arbitrates each access: round-robin on contention, CPU locked out while halted. It sequences the RAM's one-cycle registered read and returns data with a one-cycle acknowledge pulse. It sits between `subleq` and the RAM instance in `top`, and exports a stall counter for the 7-segment display mux.

## Interface
- ADDR_W, 8, word address width (RAM depth 2^ADDR_W)
- DATA_W, 32, word width
- STALL_W, 16, width of the saturating CPU stall counter
- iClock  in  1  system clock (the divided `wClock` domain)
- iReset  in  1  synchronous, active-low reset
- iCpuReq / iCpuWe  in  1 / 1  CPU access request / write enable
- iCpuAddr / iCpuWData  in  ADDR_W / DATA_W  CPU address / write data
- oCpuAck  out  1  one-cycle pulse: CPU access complete
- oCpuRData  out  DATA_W  CPU read data, valid while oCpuAck is high, held afterwards
- iDbgReq / iDbgWe / iDbgAddr / iDbgWData  in  1/1/ADDR_W/DATA_W  debug port, same meaning as CPU
- oDbgAck / oDbgRData  out  1 / DATA_W  debug ack / read data, same rules as CPU
- iHalt  in  1  high: CPU requests are never granted (loader mode)
- oMemAddr / oMemWe / oMemWData  out  ADDR_W / 1 / DATA_W  RAM port, all registered
- iMemRData  in  DATA_W  RAM read data, valid one cycle after the address is presented
- oOwner  out  1  0 = CPU, 1 = debug; owner of the current or most recent grant
- oBusy  out  1  high in ACCESS and RESP
- oStall  out  STALL_W  saturating count of cycles with iCpuReq high and no oCpuAck

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE, no eligible request: stays IDLE.
- IDLE, eligible request present: go to ACCESS.
  - Register the winner's address, write data and We onto the oMem* outputs.
  - Set oOwner to the winner.
- ACCESS: the RAM performs the write (if We) or the read.
  - oMemWe is high for exactly this one cycle.
  - Go to RESP.
- RESP:
  - Capture iMemRData into the owner's RData register (for writes as well; the value is don't-care to requesters).
  - Pulse the owner's Ack.
  - Go to IDLE.
- Eligibility:
  - Debug is always eligible.
  - CPU is eligible only when iHalt = 0.
- Contention, both eligible in IDLE: the winner is the requester other than lastOwner.
  - lastOwner is an internal register and resets to debug, so the CPU wins the first tie.
- Requester rules:
  - Hold Req and all fields stable until Ack.
  - Req still high in the cycle after Ack counts as a new request.
- iHalt rising while a CPU access is in ACCESS/RESP: that access completes normally. Only new CPU grants are blocked.
- A non-owner's Ack stays 0 and its RData register is unchanged.
- oStall:
  - Increments each cycle iCpuReq = 1 and oCpuAck = 0.
  - Saturates at all-ones and never wraps.
  - Not cleared by acks; clears only on reset.
- Reset values (iReset = 0 at a clock edge), taking effect at that edge, including mid-access:
  - State IDLE.
  - oCpuAck, oDbgAck, oMemWe = 0.
  - oMemAddr, oMemWData, oCpuRData, oDbgRData = 0.
  - oOwner = 1; lastOwner = debug.
  - oBusy = 0; oStall = 0.
  - An in-flight access is abandoned with no Ack.

## Timing
- A request sampled in IDLE at edge N:
  - oMem* is valid after edge N (ACCESS).
  - The RAM write happens at edge N+1.
  - Ack and RData are valid after edge N+1 (RESP) for one cycle.
- Latency from request sample to Ack: 2 cycles. One access per 3 cycles per port at best.
- Alternating contention: CPU, debug, CPU… with one access every 3 cycles.
- oBusy = (state != IDLE), registered with state.
- All outputs are registered. There is no combinational path from any input to any output.

## Structure
- Package `subleq_pkg`:
  - `mem_arb_state_t` enum {IDLE, ACCESS, RESP}.
  - Owner constants OWNER_CPU = 1'b0, OWNER_DBG = 1'b1.
- Sub-module `arb_rr2`: combinational 2-way round-robin pick from (req_cpu & ~iHalt, req_dbg, lastOwner) to grant/owner. It is reused by a future I/O port arbiter.
- The saturating stall counter is inline.

## Test plan
- Reset, then CPU read addr 0x05 with RAM[0x05] = 0x0000_00FF:
  - oMemAddr = 0x05 one cycle after the request.
  - oCpuAck pulses 2 cycles after the request with oCpuRData = 0x0000_00FF.
  - oOwner = 0; oStall = 2.
- Debug write 0x12 ← 0xDEAD_BEEF, then CPU read 0x12:
  - oMemWe is high exactly 1 cycle.
  - oCpuRData = 0xDEAD_BEEF.
  - oCpuAck never pulses during the debug access.
- Both Req held high for 12 cycles, iHalt = 0:
  - Ack order CPU, Dbg, CPU, Dbg.
  - Acks spaced 3 cycles apart.
  - No two Acks in the same cycle.
- iHalt = 1 with both requesting:
  - Only oDbgAck pulses and oStall increments every cycle.
  - iHalt falls: the CPU is granted within the next IDLE cycle.
- iReset low during ACCESS of a CPU write:
  - No oCpuAck; all outputs at reset values next cycle; oOwner = 1.
  - The first tie after reset goes to the CPU.
- STALL_W = 4, CPU Req held with iHalt = 1 for 20 cycles: oStall reaches 0xF and stays at 0xF.

Source files
------------

// File: rtl/subleq_pkg.sv
// Shared types and constants for the SUBLEQ machine's memory arbitration logic.
package subleq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } mem_arb_state_t;

    localparam logic OWNER_CPU = 1'b0;
    localparam logic OWNER_DBG = 1'b1;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin pick between the CPU and debug requesters.
module arb_rr2
    import subleq_pkg::*;
(
    input  logic req_cpu,
    input  logic req_dbg,
    input  logic last_owner,
    output logic grant,
    output logic owner
);

    always_comb begin
        grant = req_cpu | req_dbg;
        owner = OWNER_DBG;
        if (req_cpu && req_dbg) begin
            // On a tie the requester that did not win last time goes next.
            owner = (last_owner == OWNER_DBG) ? OWNER_CPU : OWNER_DBG;
        end else if (req_cpu) begin
            owner = OWNER_CPU;
        end
    end

endmodule

// File: rtl/subleq_mem_arbiter.sv
// Shares the single-port word RAM between the SUBLEQ core and the debug/loader port.
module subleq_mem_arbiter
    import subleq_pkg::*;
#(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned STALL_W = 16
) (
    input  logic               iClock,
    input  logic               iReset,
    input  logic               iCpuReq,
    input  logic               iCpuWe,
    input  logic [ADDR_W-1:0]  iCpuAddr,
    input  logic [DATA_W-1:0]  iCpuWData,
    output logic               oCpuAck,
    output logic [DATA_W-1:0]  oCpuRData,
    input  logic               iDbgReq,
    input  logic               iDbgWe,
    input  logic [ADDR_W-1:0]  iDbgAddr,
    input  logic [DATA_W-1:0]  iDbgWData,
    output logic               oDbgAck,
    output logic [DATA_W-1:0]  oDbgRData,
    input  logic               iHalt,
    output logic [ADDR_W-1:0]  oMemAddr,
    output logic               oMemWe,
    output logic [DATA_W-1:0]  oMemWData,
    input  logic [DATA_W-1:0]  iMemRData,
    output logic               oOwner,
    output logic               oBusy,
    output logic [STALL_W-1:0] oStall
);

    mem_arb_state_t     state_q, state_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
    logic               mem_we_q, mem_we_d;
    logic               owner_q, owner_d;
    logic               busy_q, busy_d;
    logic               cpu_ack_q, cpu_ack_d;
    logic               dbg_ack_q, dbg_ack_d;
    logic [DATA_W-1:0]  cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0]  dbg_rdata_q, dbg_rdata_d;
    logic [STALL_W-1:0] stall_q, stall_d;

    logic grant;
    logic win_owner;

    arb_rr2 u_arb (
        .req_cpu    (iCpuReq & ~iHalt),
        .req_dbg    (iDbgReq),
        .last_owner (owner_q),
        .grant      (grant),
        .owner      (win_owner)
    );

    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        owner_d     = owner_q;
        cpu_ack_d   = 1'b0;
        dbg_ack_d   = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        dbg_rdata_d = dbg_rdata_q;
        stall_d     = stall_q;

        unique case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d = ACCESS;
                    owner_d = win_owner;
                    if (win_owner == OWNER_CPU) begin
                        mem_addr_d  = iCpuAddr;
                        mem_wdata_d = iCpuWData;
                        mem_we_d    = iCpuWe;
                    end else begin
                        mem_addr_d  = iDbgAddr;
                        mem_wdata_d = iDbgWData;
                        mem_we_d    = iDbgWe;
                    end
                end
            end
            ACCESS: begin
                // Read data is sampled here so it and the ack appear together in RESP.
                state_d = RESP;
                if (owner_q == OWNER_CPU) begin
                    cpu_ack_d   = 1'b1;
                    cpu_rdata_d = iMemRData;
                end else begin
                    dbg_ack_d   = 1'b1;
                    dbg_rdata_d = iMemRData;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);

        if (iCpuReq && !cpu_ack_q && (stall_q != {STALL_W{1'b1}})) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge iClock) begin
        if (!iReset) begin
            state_q     <= IDLE;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            owner_q     <= OWNER_DBG;
            busy_q      <= 1'b0;
            cpu_ack_q   <= 1'b0;
            dbg_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
            stall_q     <= '0;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            owner_q     <= owner_d;
            busy_q      <= busy_d;
            cpu_ack_q   <= cpu_ack_d;
            dbg_ack_q   <= dbg_ack_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
            stall_q     <= stall_d;
        end
    end

    assign oMemAddr  = mem_addr_q;
    assign oMemWData = mem_wdata_q;
    assign oMemWe    = mem_we_q;
    assign oOwner    = owner_q;
    assign oBusy     = busy_q;
    assign oCpuAck   = cpu_ack_q;
    assign oDbgAck   = dbg_ack_q;
    assign oCpuRData = cpu_rdata_q;
    assign oDbgRData = dbg_rdata_q;
    assign oStall    = stall_q;

endmodule

// File: tb/tb_subleq_mem_arbiter.sv
// Directed bench for subleq_mem_arbiter; a second instance with a 4-bit stall counter checks saturation.
module tb_subleq_mem_arbiter;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 32;

    logic              clk;
    logic              rst_n;
    logic              cpu_req, cpu_we, dbg_req, dbg_we, halt;
    logic [ADDR_W-1:0] cpu_addr, dbg_addr;
    logic [DATA_W-1:0] cpu_wdata, dbg_wdata;

    logic              cpu_ack, dbg_ack, mem_we, owner, busy;
    logic [DATA_W-1:0] cpu_rdata, dbg_rdata, mem_wdata, mem_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       stall;

    logic              cpu_ack4, dbg_ack4, mem_we4, owner4, busy4;
    logic [DATA_W-1:0] cpu_rdata4, dbg_rdata4, mem_wdata4;
    logic [ADDR_W-1:0] mem_addr4;
    logic [3:0]        stall4;

    logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];

    int total = 0;
    int bad   = 0;

    subleq_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STALL_W(16)) dut (
        .iClock(clk), .iReset(rst_n),
        .iCpuReq(cpu_req), .iCpuWe(cpu_we), .iCpuAddr(cpu_addr), .iCpuWData(cpu_wdata),
        .oCpuAck(cpu_ack), .oCpuRData(cpu_rdata),
        .iDbgReq(dbg_req), .iDbgWe(dbg_we), .iDbgAddr(dbg_addr), .iDbgWData(dbg_wdata),
        .oDbgAck(dbg_ack), .oDbgRData(dbg_rdata),
        .iHalt(halt),
        .oMemAddr(mem_addr), .oMemWe(mem_we), .oMemWData(mem_wdata), .iMemRData(mem_rdata),
        .oOwner(owner), .oBusy(busy), .oStall(stall)
    );

    subleq_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STALL_W(4)) dut4 (
        .iClock(clk), .iReset(rst_n),
        .iCpuReq(cpu_req), .iCpuWe(cpu_we), .iCpuAddr(cpu_addr), .iCpuWData(cpu_wdata),
        .oCpuAck(cpu_ack4), .oCpuRData(cpu_rdata4),
        .iDbgReq(dbg_req), .iDbgWe(dbg_we), .iDbgAddr(dbg_addr), .iDbgWData(dbg_wdata),
        .oDbgAck(dbg_ack4), .oDbgRData(dbg_rdata4),
        .iHalt(halt),
        .oMemAddr(mem_addr4), .oMemWe(mem_we4), .oMemWData(mem_wdata4), .iMemRData(mem_rdata),
        .oOwner(owner4), .oBusy(busy4), .oStall(stall4)
    );

    // RAM model: write on the edge closing ACCESS, read data stable by the end of ACCESS.
    assign mem_rdata = ram[mem_addr];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Waits (bounded) for the selected ack; leaves the bench at the ack cycle.
    task automatic wait_ack(input bit sel_dbg, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            if (sel_dbg ? dbg_ack : cpu_ack) seen = 1'b1;
        end
    endtask

    initial begin
        bit          seen;
        int          we_cnt, cpu_cnt, dbg_cnt, both_cnt, n_ack, stall_err;
        bit          who [0:7];
        int          when [0:7];
        logic [15:0] stall_ref;

        for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = '0;
        ram[8'h05] = 32'h0000_00FF;
        rst_n = 1'b0; halt = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
        tick(); tick();
        check("rst_owner", owner, 1);
        check("rst_busy", busy, 0);
        check("rst_stall", stall, 0);
        check("rst_memwe", mem_we, 0);
        check("rst_cpuack", cpu_ack, 0);
        rst_n = 1'b1;
        tick();

        // CPU read of 0x05
        cpu_req = 1'b1; cpu_addr = 8'h05;
        tick();
        check("rd_memaddr", mem_addr, 8'h05);
        check("rd_busy", busy, 1);
        check("rd_owner", owner, 0);
        check("rd_ack_early", cpu_ack, 0);
        tick();
        check("rd_ack", cpu_ack, 1);
        check("rd_data", cpu_rdata, 32'h0000_00FF);
        check("rd_stall", stall, 2);
        cpu_req = 1'b0;
        tick();
        check("rd_ack_pulse", cpu_ack, 0);
        check("rd_hold", cpu_rdata, 32'h0000_00FF);
        check("rd_stall_hold", stall, 2);

        // Debug write 0x12 <- DEADBEEF
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h12; dbg_wdata = 32'hDEAD_BEEF;
        we_cnt = 0; cpu_cnt = 0; seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            if (mem_we) we_cnt++;
            if (cpu_ack) cpu_cnt++;
            if (dbg_ack) seen = 1'b1;
        end
        dbg_req = 1'b0; dbg_we = 1'b0;
        check("dw_ack", seen, 1);
        check("dw_we_cycles", we_cnt, 1);
        check("dw_no_cpuack", cpu_cnt, 0);
        check("dw_owner", owner, 1);
        tick();

        cpu_req = 1'b1; cpu_addr = 8'h12;
        wait_ack(1'b0, seen);
        cpu_req = 1'b0;
        check("cr_ack", seen, 1);
        check("cr_data", cpu_rdata, 32'hDEAD_BEEF);
        tick();

        // Debug read so the next tie goes to the CPU
        dbg_req = 1'b1; dbg_addr = 8'h12;
        wait_ack(1'b1, seen);
        dbg_req = 1'b0;
        check("dr_ack", seen, 1);
        check("dr_data", dbg_rdata, 32'hDEAD_BEEF);
        tick();

        // Contention for 12 cycles
        cpu_req = 1'b1; cpu_addr = 8'h05; dbg_req = 1'b1; dbg_addr = 8'h12;
        n_ack = 0; both_cnt = 0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (cpu_ack && dbg_ack) both_cnt++;
            if ((cpu_ack || dbg_ack) && n_ack < 8) begin
                who[n_ack] = dbg_ack;
                when[n_ack] = c;
                n_ack++;
            end
        end
        cpu_req = 1'b0; dbg_req = 1'b0;
        check("rr_count", n_ack, 4);
        check("rr_both", both_cnt, 0);
        if (n_ack == 4) begin
            check("rr_who0", who[0], 0);
            check("rr_who1", who[1], 1);
            check("rr_who2", who[2], 0);
            check("rr_who3", who[3], 1);
            check("rr_first", when[0], 2);
            check("rr_gap1", when[1] - when[0], 3);
            check("rr_gap2", when[2] - when[1], 3);
            check("rr_gap3", when[3] - when[2], 3);
        end

        // Halt with both requesting
        halt = 1'b1; cpu_req = 1'b1; dbg_req = 1'b1;
        stall_ref = stall; cpu_cnt = 0; dbg_cnt = 0; stall_err = 0;
        for (int c = 1; c <= 9; c++) begin
            tick();
            stall_ref = stall_ref + 16'd1;
            if (stall !== stall_ref) stall_err++;
            if (cpu_ack) cpu_cnt++;
            if (dbg_ack) dbg_cnt++;
        end
        check("halt_cpuack", cpu_cnt, 0);
        check("halt_dbgack", dbg_cnt, 3);
        check("halt_stall_err", stall_err, 0);
        halt = 1'b0;
        tick();
        check("unhalt_owner", owner, 0);
        check("unhalt_busy", busy, 1);
        tick();
        check("unhalt_ack", cpu_ack, 1);
        cpu_req = 1'b0; dbg_req = 1'b0;
        tick(); tick();

        // Reset during ACCESS of a CPU write
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h30; cpu_wdata = 32'h0000_1234;
        tick();
        check("rw_access_we", mem_we, 1);
        rst_n = 1'b0;
        tick();
        cpu_req = 1'b0; cpu_we = 1'b0; rst_n = 1'b1;
        check("rw_no_ack", cpu_ack, 0);
        check("rw_owner", owner, 1);
        check("rw_busy", busy, 0);
        check("rw_memwe", mem_we, 0);
        check("rw_memaddr", mem_addr, 0);
        check("rw_memwdata", mem_wdata, 0);
        check("rw_cpurdata", cpu_rdata, 0);
        check("rw_dbgrdata", dbg_rdata, 0);
        check("rw_stall", stall, 0);
        tick();
        check("rw_still_no_ack", cpu_ack, 0);

        cpu_req = 1'b1; cpu_addr = 8'h05; dbg_req = 1'b1; dbg_addr = 8'h05;
        tick();
        check("tie_owner", owner, 0);
        tick();
        check("tie_cpuack", cpu_ack, 1);
        check("tie_dbgack", dbg_ack, 0);
        cpu_req = 1'b0;
        wait_ack(1'b1, seen);
        dbg_req = 1'b0;
        check("tie_dbg_follow", seen, 1);
        tick();

        // Saturation of the 4-bit counter
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("sat_rst", stall4, 0);
        halt = 1'b1; cpu_req = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (c == 15) check("sat_reach", stall4, 4'hF);
        end
        check("sat_stay", stall4, 4'hF);
        check("sat_wide", stall, 20);
        check("sat_no_ack", cpu_ack4, 0);
        halt = 1'b0; cpu_req = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
